// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU op sequencer: FSM states, ALU select
// encodings and the response flag payload.
package alu_op_sequencer_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_INC,
        ST_RESP
    } state_e;

    localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
    localparam logic [SEL_W-1:0] OP_AND = 3'b100;
    localparam logic [SEL_W-1:0] OP_OR  = 3'b101;
    localparam logic [SEL_W-1:0] OP_XOR = 3'b110;
    localparam logic [SEL_W-1:0] OP_NOT = 3'b111;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
    } rsp_flags_t;

    // Any select with bit 2 clear is an add on the ALU.
    function automatic logic is_add(input logic [SEL_W-1:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/alu_op_sequencer_flag_gen.sv
// Combinational C/Z/N flag generation for a completed 8- or 16-bit result.
module alu_flag_gen
    import alu_op_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] result,
    input  logic              wide,
    input  logic              add,
    input  logic              carry,
    output rsp_flags_t        flags_c
);

    always_comb begin
        flags_c   = '0;
        flags_c.c = add & carry;
        flags_c.z = wide ? (result == '0) : (result[BYTE_W-1:0] == '0);
        flags_c.n = wide ? result[DATA_W-1] : result[BYTE_W-1];
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues 8/16-bit commands to an external combinational 8-bit ALU one byte per
// cycle, chains add carry via an increment pass, and returns result plus flags.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic              cmd_wide,
    input  logic [15:0]       cmd_a,
    input  logic [15:0]       cmd_b,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_sel,
    input  logic [7:0]        alu_result,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
    output logic              rsp_c,
    output logic              rsp_z,
    output logic              rsp_n,
    output logic [CNT_W-1:0]  ops_done
);

    state_e              state, next_state;
    logic [SEL_W-1:0]    op_q;
    logic                wide_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [BYTE_W-1:0]   lo_q, hi_q, lo_d, hi_d;
    logic                c0_q, c1_q, c0_d, c1_d;
    logic [BYTE_W-1:0]   alu_a_d, alu_b_d;
    logic [SEL_W-1:0]    alu_sel_d;
    logic                accept;
    logic                rsp_load;
    rsp_flags_t          flags_c, flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next state, byte capture values and the ALU drive for the next state.
    always_comb begin
        next_state = state;
        lo_d       = lo_q;
        hi_d       = hi_q;
        c0_d       = c0_q;
        c1_d       = c1_q;
        alu_a_d    = '0;
        alu_b_d    = '0;
        alu_sel_d  = '0;
        accept     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    next_state = ST_LO;
                    alu_a_d    = cmd_a[BYTE_W-1:0];
                    alu_b_d    = cmd_b[BYTE_W-1:0];
                    alu_sel_d  = cmd_op;
                end
            end
            ST_LO: begin
                lo_d = alu_result;
                c0_d = alu_cout;
                if (wide_q) begin
                    next_state = ST_HI;
                    alu_a_d    = a_q[DATA_W-1:BYTE_W];
                    alu_b_d    = b_q[DATA_W-1:BYTE_W];
                    alu_sel_d  = op_q;
                end else begin
                    next_state = ST_RESP;
                    hi_d       = '0;
                    c1_d       = 1'b0;
                end
            end
            ST_HI: begin
                hi_d = alu_result;
                c1_d = alu_cout;
                if (is_add(op_q) && c0_q) begin
                    next_state = ST_INC;
                    alu_a_d    = alu_result;
                    alu_b_d    = BYTE_W'(1);
                    alu_sel_d  = OP_ADD;
                end else begin
                    next_state = ST_RESP;
                end
            end
            ST_INC: begin
                hi_d       = alu_result;
                c1_d       = c1_q | alu_cout;
                next_state = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign rsp_load = (state != ST_RESP) && (next_state == ST_RESP);

    alu_flag_gen u_flag_gen (
        .result  ({hi_d, lo_d}),
        .wide    (wide_q),
        .add     (is_add(op_q)),
        .carry   (wide_q ? c1_d : c0_d),
        .flags_c (flags_c)
    );

    // Command, byte accumulators and registered outward-facing signals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            wide_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            c0_q      <= 1'b0;
            c1_q      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            flags_q   <= '0;
            ops_done  <= '0;
        end else begin
            if (accept) begin
                op_q   <= cmd_op;
                wide_q <= cmd_wide;
                a_q    <= cmd_a;
                b_q    <= cmd_b;
            end
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            c0_q      <= c0_d;
            c1_q      <= c1_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_sel   <= alu_sel_d;
            cmd_ready <= (next_state == ST_IDLE);
            rsp_valid <= (next_state == ST_RESP);
            if (rsp_load) begin
                rsp_data <= {hi_d, lo_d};
                flags_q  <= flags_c;
            end
            if (state == ST_RESP && rsp_ready) ops_done <= ops_done + CNT_W'(1);
        end
    end

    assign rsp_c = flags_q.c;
    assign rsp_z = flags_q.z;
    assign rsp_n = flags_q.n;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_op_sequencer;

    localparam int unsigned TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [2:0]          cmd_op = '0;
    logic                cmd_wide = 1'b0;
    logic [15:0]         cmd_a = '0;
    logic [15:0]         cmd_b = '0;
    logic [7:0]          alu_a, alu_b;
    logic [2:0]          alu_sel;
    logic [7:0]          alu_result;
    logic                alu_cout;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [15:0]         rsp_data;
    logic                rsp_c, rsp_z, rsp_n;
    logic [TB_CNT_W-1:0] ops_done;

    int errors = 0;
    int checks = 0;
    logic [TB_CNT_W-1:0] exp_ops = '0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_wide(cmd_wide), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_n(rsp_n), .ops_done(ops_done)
    );

    // External combinational ALU
    always_comb begin
        alu_cout = 1'b0;
        if (!alu_sel[2]) begin
            {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
        end else begin
            case (alu_sel[1:0])
                2'b00:   alu_result = alu_a & alu_b;
                2'b01:   alu_result = alu_a | alu_b;
                2'b10:   alu_result = alu_a ^ alu_b;
                default: alu_result = ~alu_a;
            endcase
        end
    end

    // Issue one command; returns edges from accept to rsp_valid, the LO-cycle
    // alu_a and the third-cycle alu_b/alu_sel.
    task automatic issue(input logic [2:0] op, input logic wide,
                         input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic [7:0] a_at1,
                         output logic [7:0] b_at3, output logic [2:0] sel_at3);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_wide = wide; cmd_a = a; cmd_b = b;
        while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL issue_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_a = 16'hDEAD; cmd_b = 16'hBEEF;
        lat = 1; a_at1 = alu_a; b_at3 = 8'hxx; sel_at3 = 3'bxxx;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (lat == 3) begin b_at3 = alu_b; sel_at3 = alu_sel; end
        end
    endtask

    task automatic take_rsp;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_ops = exp_ops + TB_CNT_W'(1);
        checks++;
        if (ops_done !== exp_ops || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL take_rsp: ops_done=%0d rsp_valid=%b cmd_ready=%b required %0d 0 1",
                     ops_done, rsp_valid, cmd_ready, exp_ops);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_c, rsp_z, rsp_n, ops_done, alu_a, alu_b, alu_sel} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b data=%h czn=%b%b%b ops=%0d alu=%h/%h/%h required all 0",
                     cmd_ready, rsp_valid, rsp_data, rsp_c, rsp_z, rsp_n, ops_done, alu_a, alu_b, alu_sel);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b rsp_valid=%b required 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_narrow_add;
        int lat; logic [7:0] a1, b3; logic [2:0] s3;
        issue(3'b000, 1'b0, 16'h55F0, 16'h7720, lat, a1, b3, s3);
        checks++;
        if (lat !== 2 || a1 !== 8'hF0) begin
            errors++;
            $display("FAIL narrow_add_timing: lat=%0d lo_alu_a=%h required 2 f0", lat, a1);
        end
        checks++;
        if ({rsp_data, rsp_c, rsp_z, rsp_n} !== {16'h0010, 3'b100}) begin
            errors++;
            $display("FAIL narrow_add_rsp: data=%h czn=%b%b%b required 0010 100", rsp_data, rsp_c, rsp_z, rsp_n);
        end
        take_rsp();
    endtask

    task automatic test_wide_add_carry;
        int lat; logic [7:0] a1, b3; logic [2:0] s3;
        issue(3'b000, 1'b1, 16'h00FF, 16'h0001, lat, a1, b3, s3);
        checks++;
        if (lat !== 4 || b3 !== 8'h01 || s3 !== 3'b000) begin
            errors++;
            $display("FAIL wide_carry_timing: lat=%0d inc_alu_b=%h inc_sel=%b required 4 01 000", lat, b3, s3);
        end
        checks++;
        if ({rsp_data, rsp_c, rsp_z, rsp_n} !== {16'h0100, 3'b000}) begin
            errors++;
            $display("FAIL wide_carry_rsp: data=%h czn=%b%b%b required 0100 000", rsp_data, rsp_c, rsp_z, rsp_n);
        end
        take_rsp();
    endtask

    task automatic test_wide_overflow;
        int lat; logic [7:0] a1, b3; logic [2:0] s3;
        issue(3'b011, 1'b1, 16'hFFFF, 16'h0001, lat, a1, b3, s3);
        checks++;
        if (lat !== 4 || {rsp_data, rsp_c, rsp_z, rsp_n} !== {16'h0000, 3'b110}) begin
            errors++;
            $display("FAIL wide_overflow: lat=%0d data=%h czn=%b%b%b required 4 0000 110",
                     lat, rsp_data, rsp_c, rsp_z, rsp_n);
        end
        take_rsp();
    endtask

    task automatic test_wide_logic;
        int lat; logic [7:0] a1, b3; logic [2:0] s3;
        issue(3'b111, 1'b1, 16'h00F0, 16'h5A5A, lat, a1, b3, s3);
        checks++;
        if (lat !== 3 || {rsp_data, rsp_c, rsp_z, rsp_n} !== {16'hFF0F, 3'b001}) begin
            errors++;
            $display("FAIL wide_not: lat=%0d data=%h czn=%b%b%b required 3 ff0f 001",
                     lat, rsp_data, rsp_c, rsp_z, rsp_n);
        end
        take_rsp();
        issue(3'b110, 1'b1, 16'h1234, 16'h1234, lat, a1, b3, s3);
        checks++;
        if (lat !== 3 || {rsp_data, rsp_c, rsp_z, rsp_n} !== {16'h0000, 3'b010}) begin
            errors++;
            $display("FAIL wide_xor: lat=%0d data=%h czn=%b%b%b required 3 0000 010",
                     lat, rsp_data, rsp_c, rsp_z, rsp_n);
        end
        take_rsp();
        // wide add without low carry skips the increment pass
        issue(3'b000, 1'b1, 16'h8001, 16'h0102, lat, a1, b3, s3);
        checks++;
        if (lat !== 3 || {rsp_data, rsp_c, rsp_z, rsp_n} !== {16'h8103, 3'b001}) begin
            errors++;
            $display("FAIL wide_add_nocarry: lat=%0d data=%h czn=%b%b%b required 3 8103 001",
                     lat, rsp_data, rsp_c, rsp_z, rsp_n);
        end
        take_rsp();
    endtask

    task automatic test_narrow_not;
        int lat; logic [7:0] a1, b3; logic [2:0] s3;
        issue(3'b111, 1'b0, 16'hAB0F, 16'h0000, lat, a1, b3, s3);
        checks++;
        if (lat !== 2 || {rsp_data, rsp_c, rsp_z, rsp_n} !== {16'h00F0, 3'b001}) begin
            errors++;
            $display("FAIL narrow_not: lat=%0d data=%h czn=%b%b%b required 2 00f0 001",
                     lat, rsp_data, rsp_c, rsp_z, rsp_n);
        end
        take_rsp();
        issue(3'b101, 1'b0, 16'hFF00, 16'hFF00, lat, a1, b3, s3);
        checks++;
        if ({rsp_data, rsp_c, rsp_z, rsp_n} !== {16'h0000, 3'b010}) begin
            errors++;
            $display("FAIL narrow_or_zero: data=%h czn=%b%b%b required 0000 010", rsp_data, rsp_c, rsp_z, rsp_n);
        end
        take_rsp();
    endtask

    task automatic test_backpressure;
        int lat; logic [7:0] a1, b3; logic [2:0] s3;
        int bad = 0;
        issue(3'b101, 1'b0, 16'h0012, 16'h0021, lat, a1, b3, s3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h0033 || cmd_ready !== 1'b0 || ops_done !== exp_ops)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: bad_cycles=%0d valid=%b data=%h ready=%b ops=%0d required 0 1 0033 0 %0d",
                     bad, rsp_valid, rsp_data, cmd_ready, ops_done, exp_ops);
        end
        take_rsp();
    endtask

    task automatic test_reset_mid_op;
        int lat; logic [7:0] a1, b3; logic [2:0] s3;
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_wide = 1'b1; cmd_a = 16'h5511; cmd_b = 16'h2233;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (alu_a !== 8'h55 || alu_b !== 8'h22) begin
            errors++;
            $display("FAIL mid_op_hi_drive: alu_a=%h alu_b=%h required 55 22", alu_a, alu_b);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_ops = '0;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_c, rsp_z, rsp_n, ops_done, alu_a, alu_b, alu_sel} !== '0) begin
            errors++;
            $display("FAIL mid_op_reset: ready=%b valid=%b data=%h ops=%0d alu=%h/%h/%h required all 0",
                     cmd_ready, rsp_valid, rsp_data, ops_done, alu_a, alu_b, alu_sel);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        issue(3'b100, 1'b0, 16'h00AA, 16'h000F, lat, a1, b3, s3);
        checks++;
        if (lat !== 2 || {rsp_data, rsp_c, rsp_z, rsp_n} !== {16'h000A, 3'b000}) begin
            errors++;
            $display("FAIL post_reset_and: lat=%0d data=%h czn=%b%b%b required 2 000a 000",
                     lat, rsp_data, rsp_c, rsp_z, rsp_n);
        end
        take_rsp();
    endtask

    task automatic test_wrap;
        int lat; logic [7:0] a1, b3; logic [2:0] s3;
        while (exp_ops != '1) begin
            issue(3'b000, 1'b0, 16'h0001, 16'h0001, lat, a1, b3, s3);
            take_rsp();
        end
        issue(3'b000, 1'b0, 16'h0001, 16'h0001, lat, a1, b3, s3);
        take_rsp();
        checks++;
        if (ops_done !== '0) begin
            errors++;
            $display("FAIL ops_wrap: ops_done=%0d required 0", ops_done);
        end
    endtask

    initial begin
        test_reset();
        test_narrow_add();
        test_wide_add_carry();
        test_wide_overflow();
        test_wide_logic();
        test_narrow_not();
        test_backpressure();
        test_reset_mid_op();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
